// File: rtl/ddr_if_pkg.sv
`default_nettype none
// ==== ddr_if_pkg : shared types for the simddr request path (rev 1.0) ====
package ddr_if_pkg;

   localparam int DDR_LINE_W = 512;
   localparam int DDR_ADDR_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   // Request as latched at accept; drives the DDR issue signals until the next accept.
   typedef struct packed {
      logic [DDR_ADDR_W-1:0] addr;
      logic                  wen;
      logic [DDR_LINE_W-1:0] wmask;
      logic [DDR_LINE_W-1:0] wdata;
   } ddr_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ==== rr_arb2 : two-way round-robin between fetch and LSU, last grant updated on accept (rev 1.0) ====
module rr_arb2
   import ddr_if_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic req_if,
   input  logic req_lsu,
   input  logic accept_if,
   input  logic accept_lsu,
   output logic grant_if,
   output logic grant_lsu
);

   owner_e last_q;
   owner_e last_d;

   always_comb begin
      // A port is held back only while the other port asks and it was the one served last.
      grant_if  = !(req_lsu && (last_q == OWN_IF));
      grant_lsu = !(req_if && (last_q == OWN_LSU));
      last_d    = last_q;
      if (accept_if) begin
         last_d = OWN_IF;
      end else if (accept_lsu) begin
         last_d = OWN_LSU;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= OWN_LSU;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ddr_req_arbiter.sv
`default_nettype none
// ==== ddr_req_arbiter : fetch/LSU line-request arbiter driving simddr, one burst at a time (rev 1.0) ====
module ddr_req_arbiter
   import ddr_if_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset_n,

   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [DDR_ADDR_W-1:0] if_req_addr,
   output logic                  if_resp_valid,
   output logic [DDR_LINE_W-1:0] if_resp_data,

   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [DDR_ADDR_W-1:0] lsu_req_addr,
   input  logic                  lsu_req_wen,
   input  logic [DDR_LINE_W-1:0] lsu_req_wmask,
   input  logic [DDR_LINE_W-1:0] lsu_req_wdata,
   output logic                  lsu_resp_valid,
   output logic [DDR_LINE_W-1:0] lsu_resp_data,

   output logic                  ddr_chip_enable,
   output logic [DDR_ADDR_W-1:0] ddr_index,
   output logic                  ddr_write_enable,
   output logic                  ddr_burst_mode,
   output logic [DDR_LINE_W-1:0] ddr_write_mask,
   output logic [DDR_LINE_W-1:0] ddr_write_data,
   input  logic [DDR_LINE_W-1:0] ddr_read_data,
   input  logic                  ddr_operation_done,
   input  logic                  ddr_ready,
   output logic                  ddr_timeout
);

   localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   arb_state_e            state_q, state_d;
   owner_e                owner_q, owner_d;
   ddr_req_t              req_q, req_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic                  timeout_q, timeout_d;
   logic [DDR_LINE_W-1:0] if_data_q, if_data_d;
   logic [DDR_LINE_W-1:0] lsu_data_q, lsu_data_d;

   logic grant_if, grant_lsu;
   logic accept_if, accept_lsu;
   logic idle_ok;

   rr_arb2 u_arb (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_if     (if_req_valid),
      .req_lsu    (lsu_req_valid),
      .accept_if  (accept_if),
      .accept_lsu (accept_lsu),
      .grant_if   (grant_if),
      .grant_lsu  (grant_lsu)
   );

   // Readies are gated by reset so every output sits at its reset value while reset is held.
   assign idle_ok       = reset_n && (state_q == ST_IDLE) && ddr_ready;
   assign if_req_ready  = idle_ok && grant_if;
   assign lsu_req_ready = idle_ok && grant_lsu;
   assign accept_if     = if_req_valid && if_req_ready;
   assign accept_lsu    = lsu_req_valid && lsu_req_ready;
   assign cnt_inc       = cnt_q + CNT_ONE;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      req_d      = req_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      if_data_d  = if_data_q;
      lsu_data_d = lsu_data_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_if) begin
               owner_d     = OWN_IF;
               req_d.addr  = if_req_addr;
               req_d.wen   = 1'b0;
               req_d.wmask = '0;
               req_d.wdata = '0;
               state_d     = ST_ISSUE;
            end else if (accept_lsu) begin
               owner_d     = OWN_LSU;
               req_d.addr  = lsu_req_addr;
               req_d.wen   = lsu_req_wen;
               req_d.wmask = lsu_req_wmask;
               req_d.wdata = lsu_req_wdata;
               state_d     = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // A completion arriving on the last allowed cycle still wins over the watchdog.
            if (ddr_operation_done) begin
               if (!req_q.wen) begin
                  if (owner_q == OWN_IF) begin
                     if_data_d = ddr_read_data;
                  end else begin
                     lsu_data_d = ddr_read_data;
                  end
               end
               state_d = ST_RESP;
            end else if (cnt_inc == CNT_LIMIT) begin
               timeout_d = 1'b1;
               if (owner_q == OWN_IF) begin
                  if_data_d = '0;
               end else begin
                  lsu_data_d = '0;
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         req_q      <= '0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         if_data_q  <= '0;
         lsu_data_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         req_q      <= req_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         if_data_q  <= if_data_d;
         lsu_data_q <= lsu_data_d;
      end
   end

   assign ddr_chip_enable  = (state_q == ST_ISSUE);
   assign ddr_index        = req_q.addr;
   assign ddr_write_enable = req_q.wen;
   assign ddr_write_mask   = req_q.wmask;
   assign ddr_write_data   = req_q.wdata;
   assign ddr_burst_mode   = 1'b1;
   assign ddr_timeout      = timeout_q;

   assign if_resp_valid    = (state_q == ST_RESP) && (owner_q == OWN_IF);
   assign lsu_resp_valid   = (state_q == ST_RESP) && (owner_q == OWN_LSU);
   assign if_resp_data     = if_data_q;
   assign lsu_resp_data    = lsu_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_req_arbiter.sv
`default_nettype none
// ==== tb_ddr_req_arbiter : randomized bench for ddr_req_arbiter against a transaction-level model (rev 1.0) ====
module tb_ddr_req_arbiter;

   localparam int TO = 16;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         if_req_valid, if_req_ready, if_resp_valid;
   logic [63:0]  if_req_addr;
   logic [511:0] if_resp_data;
   logic         lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
   logic [63:0]  lsu_req_addr;
   logic [511:0] lsu_req_wmask, lsu_req_wdata, lsu_resp_data;
   logic         ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
   logic [63:0]  ddr_index;
   logic [511:0] ddr_write_mask, ddr_write_data, ddr_read_data;
   logic         ddr_operation_done, ddr_ready, ddr_timeout;

   ddr_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wmask(lsu_req_wmask), .lsu_req_wdata(lsu_req_wdata),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
      .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index), .ddr_write_enable(ddr_write_enable),
      .ddr_burst_mode(ddr_burst_mode), .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
      .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready),
      .ddr_timeout(ddr_timeout)
   );

   always #5 clock = ~clock;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Model: one transaction at a time described by the cycle numbers of its events.
   bit           m_last;   // 0 = fetch served last, 1 = LSU served last
   bit           m_own, m_wen, m_to, m_timeout;
   logic [63:0]  m_addr;
   logic [511:0] m_mask, m_wdata, m_if_data, m_lsu_data;
   int           m_ce_at, m_done_at, m_resp_at, m_free_at;
   logic [511:0] mem [logic [63:0]];

   // Stimulus state and knobs.
   bit           if_pend, lsu_pend, lsu_w;
   logic [63:0]  if_a, lsu_a;
   logic [511:0] lsu_m, lsu_d;
   bit           gen_en, to_next, rereq, noise_en, force_done;
   int           rdy_mode, lat_fix;

   // Observations of the DUT, used by the directed scenarios.
   int           obs_ce, obs_if_rv, obs_lsu_rv;
   logic [63:0]  obs_idx;
   bit           obs_wen;
   logic [511:0] obs_mask, obs_wd;
   bit           acc_log [$];

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   function automatic logic [63:0] rand_addr();
      return 64'h8000_0000 + 64'($urandom_range(0, 15)) * 64'd64;
   endfunction

   function automatic logic [511:0] mem_rd(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return {8{a ^ 64'h0123_4567_89AB_CDEF}};
   endfunction

   task automatic new_lsu();
      lsu_pend = 1'b1;
      lsu_a    = rand_addr();
      lsu_w    = ($urandom_range(0, 1) == 1);
      lsu_m    = rand_line();
      lsu_d    = rand_line();
   endtask

   task automatic model_reset();
      m_last = 1'b1; m_own = 1'b0; m_wen = 1'b0; m_to = 1'b0; m_timeout = 1'b0;
      m_addr = '0; m_mask = '0; m_wdata = '0; m_if_data = '0; m_lsu_data = '0;
      m_ce_at = -10; m_done_at = -10; m_resp_at = -10; m_free_at = cyc;
   endtask

   task automatic check_reset_vals();
      check_eq("rst_ce",      512'(ddr_chip_enable),  512'(0));
      check_eq("rst_idx",     512'(ddr_index),        512'(0));
      check_eq("rst_wen",     512'(ddr_write_enable), 512'(0));
      check_eq("rst_mask",    ddr_write_mask,         512'(0));
      check_eq("rst_wdata",   ddr_write_data,         512'(0));
      check_eq("rst_burst",   512'(ddr_burst_mode),   512'(1));
      check_eq("rst_if_rv",   512'(if_resp_valid),    512'(0));
      check_eq("rst_lsu_rv",  512'(lsu_resp_valid),   512'(0));
      check_eq("rst_if_rd",   if_resp_data,           512'(0));
      check_eq("rst_lsu_rd",  lsu_resp_data,          512'(0));
      check_eq("rst_tmo",     512'(ddr_timeout),      512'(0));
      check_eq("rst_if_rdy",  512'(if_req_ready),     512'(0));
      check_eq("rst_lsu_rdy", 512'(lsu_req_ready),    512'(0));
   endtask

   // One clock: entered just after a falling edge, left at the next falling edge.
   task automatic tick();
      bit idle, e_if_rdy, e_lsu_rdy, acc_if, acc_lsu, in_wait;
      int lat;
      if (gen_en) begin
         if (!if_pend && $urandom_range(0, 2) == 0) begin if_pend = 1'b1; if_a = rand_addr(); end
         if (!lsu_pend && $urandom_range(0, 2) == 0) new_lsu();
      end
      if_req_valid  = if_pend;
      if_req_addr   = if_pend ? if_a : rand_addr();
      lsu_req_valid = lsu_pend;
      lsu_req_addr  = lsu_pend ? lsu_a : rand_addr();
      lsu_req_wen   = lsu_pend ? lsu_w : ($urandom_range(0, 1) == 1);
      lsu_req_wmask = lsu_pend ? lsu_m : rand_line();
      lsu_req_wdata = lsu_pend ? lsu_d : rand_line();
      case (rdy_mode)
         1:       ddr_ready = 1'b0;
         2:       ddr_ready = 1'b1;
         default: ddr_ready = ($urandom_range(0, 4) != 0);
      endcase
      in_wait = (cyc > m_ce_at) && (cyc < m_resp_at);
      ddr_operation_done = (cyc == m_done_at) || force_done ||
                           (noise_en && !in_wait && $urandom_range(0, 3) == 0);
      ddr_read_data = (cyc == m_done_at) ? mem_rd(m_addr) : rand_line();
      #1;
      idle      = (cyc >= m_free_at);
      e_if_rdy  = idle && ddr_ready && !(lsu_req_valid && !m_last);
      e_lsu_rdy = idle && ddr_ready && !(if_req_valid && m_last);
      check_eq("if_ready",  512'(if_req_ready),     512'(e_if_rdy));
      check_eq("lsu_ready", 512'(lsu_req_ready),    512'(e_lsu_rdy));
      check_eq("chip_en",   512'(ddr_chip_enable),  512'(cyc == m_ce_at));
      check_eq("if_rv",     512'(if_resp_valid),    512'((cyc == m_resp_at) && !m_own));
      check_eq("lsu_rv",    512'(lsu_resp_valid),   512'((cyc == m_resp_at) && m_own));
      check_eq("if_rdata",  if_resp_data,           m_if_data);
      check_eq("lsu_rdata", lsu_resp_data,          m_lsu_data);
      check_eq("index",     512'(ddr_index),        512'(m_addr));
      check_eq("wen",       512'(ddr_write_enable), 512'(m_wen));
      check_eq("wmask",     ddr_write_mask,         m_mask);
      check_eq("wdata",     ddr_write_data,         m_wdata);
      check_eq("burst",     512'(ddr_burst_mode),   512'(1));
      check_eq("timeout",   512'(ddr_timeout),      512'(m_timeout));

      if (ddr_chip_enable) begin
         obs_ce++;
         obs_idx = ddr_index; obs_wen = ddr_write_enable; obs_mask = ddr_write_mask; obs_wd = ddr_write_data;
      end
      if (if_resp_valid) obs_if_rv++;
      if (lsu_resp_valid) obs_lsu_rv++;
      if (if_req_valid && if_req_ready) acc_log.push_back(1'b0);
      if (lsu_req_valid && lsu_req_ready) acc_log.push_back(1'b1);

      acc_if  = if_req_valid && e_if_rdy;
      acc_lsu = lsu_req_valid && e_lsu_rdy;
      @(posedge clock);
      if (cyc == m_resp_at - 1) begin
         if (m_to) begin
            m_timeout = 1'b1;
            if (m_own) m_lsu_data = '0; else m_if_data = '0;
         end else if (m_wen) begin
            mem[m_addr] = (mem_rd(m_addr) & ~m_mask) | (m_wdata & m_mask);
         end else if (m_own) begin
            m_lsu_data = ddr_read_data;
         end else begin
            m_if_data = ddr_read_data;
         end
      end
      if (acc_if || acc_lsu) begin
         m_own   = acc_lsu && !acc_if;
         m_last  = m_own;
         m_addr  = acc_if ? if_req_addr : lsu_req_addr;
         m_wen   = acc_if ? 1'b0 : lsu_req_wen;
         m_mask  = acc_if ? '0 : lsu_req_wmask;
         m_wdata = acc_if ? '0 : lsu_req_wdata;
         m_ce_at = cyc + 1;
         m_to    = to_next;
         to_next = 1'b0;
         lat     = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 6));
         if (m_to) begin
            m_done_at = -10;
            m_resp_at = cyc + 2 + TO;
         end else begin
            m_done_at = cyc + 2 + lat;
            m_resp_at = m_done_at + 1;
         end
         m_free_at = m_resp_at + 1;
         if (acc_if) begin
            if_pend = 1'b0;
            if (rereq) begin if_pend = 1'b1; if_a = rand_addr(); end
         end else begin
            lsu_pend = 1'b0;
            if (rereq) new_lsu();
         end
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while ((if_pend || lsu_pend || cyc < m_free_at) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain_budget", 512'(if_pend || lsu_pend || cyc < m_free_at), 512'(0));
   endtask

   initial begin
      int ce0, ifr0, lsur0, old_ce, n;
      bit exp_order [4];
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

      if_req_valid = 0; if_req_addr = '0; lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0;
      lsu_req_wmask = '0; lsu_req_wdata = '0; ddr_read_data = '0; ddr_operation_done = 0; ddr_ready = 0;
      if_pend = 0; lsu_pend = 0; gen_en = 0; to_next = 0; rereq = 0; noise_en = 0; force_done = 0;
      rdy_mode = 0; lat_fix = -1; obs_ce = 0; obs_if_rv = 0; obs_lsu_rv = 0;
      model_reset();
      #2;
      check_reset_vals();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();

      // Random traffic from both ports.
      gen_en = 1; noise_en = 1;
      repeat (400) tick();
      gen_en = 0;
      run_until_idle(100);

      // Fetch read of a known line.
      ce0 = obs_ce; ifr0 = obs_if_rv; lsur0 = obs_lsu_rv;
      if_pend = 1; if_a = 64'h8000_0040;
      run_until_idle(40);
      check_eq("fetch_ce_cnt",   512'(obs_ce - ce0),         512'(1));
      check_eq("fetch_index",    512'(obs_idx),              512'(64'h8000_0040));
      check_eq("fetch_wen",      512'(obs_wen),              512'(0));
      check_eq("fetch_rv_cnt",   512'(obs_if_rv - ifr0),     512'(1));
      check_eq("fetch_lsu_rv",   512'(obs_lsu_rv - lsur0),   512'(0));
      check_eq("fetch_line",     if_resp_data,               mem_rd(64'h8000_0040));

      // LSU write with an A5 pattern.
      ce0 = obs_ce; lsur0 = obs_lsu_rv;
      lsu_pend = 1; lsu_a = 64'h8000_0100; lsu_w = 1; lsu_m = rand_line(); lsu_d = {64{8'hA5}};
      run_until_idle(40);
      check_eq("wr_ce_cnt",  512'(obs_ce - ce0),       512'(1));
      check_eq("wr_index",   512'(obs_idx),            512'(64'h8000_0100));
      check_eq("wr_wen",     512'(obs_wen),            512'(1));
      check_eq("wr_data",    obs_wd,                   {64{8'hA5}});
      check_eq("wr_mask",    obs_mask,                 lsu_m);
      check_eq("wr_rv_cnt",  512'(obs_lsu_rv - lsur0), 512'(1));
      check_eq("wr_rdata",   lsu_resp_data,            m_lsu_data);

      // Simultaneous requests, twice in a row, with immediate re-requests.
      acc_log.delete();
      if_pend = 1; if_a = rand_addr(); new_lsu();
      rereq = 1; n = 0;
      while (acc_log.size() < 4 && n < 120) begin tick(); n++; end
      rereq = 0;
      run_until_idle(100);
      check_eq("tie_count", 512'(acc_log.size() >= 4), 512'(1));
      for (int k = 0; k < 4; k++) begin
         if (k < acc_log.size()) check_eq($sformatf("tie_order%0d", k), 512'(acc_log[k]), 512'(exp_order[k]));
      end

      // DDR busy in IDLE blocks acceptance.
      acc_log.delete(); ce0 = obs_ce;
      rdy_mode = 1; lsu_pend = 1; lsu_a = rand_addr(); lsu_w = 0; lsu_m = rand_line(); lsu_d = rand_line();
      repeat (5) tick();
      check_eq("busy_no_acc", 512'(acc_log.size()),  512'(0));
      check_eq("busy_no_ce",  512'(obs_ce - ce0),    512'(0));
      rdy_mode = 2;
      tick();
      check_eq("busy_acc",    512'(acc_log.size()),  512'(1));
      rdy_mode = 0;
      run_until_idle(40);

      // Watchdog: no completion for a fetch.
      to_next = 1; if_pend = 1; if_a = 64'h8000_0200; ifr0 = obs_if_rv;
      run_until_idle(60);
      check_eq("tmo_flag",    512'(ddr_timeout),       512'(1));
      check_eq("tmo_rv_cnt",  512'(obs_if_rv - ifr0), 512'(1));
      check_eq("tmo_data",    if_resp_data,            512'(0));
      new_lsu();
      run_until_idle(40);
      check_eq("tmo_sticky",  512'(ddr_timeout),       512'(1));

      // Reset asserted in the middle of WAIT.
      lat_fix = 10; old_ce = m_ce_at; n = 0;
      lsu_pend = 1; lsu_a = 64'h8000_0300; lsu_w = 0; lsu_m = rand_line(); lsu_d = rand_line();
      while (!(m_ce_at != old_ce && cyc == m_ce_at + 3) && n < 40) begin tick(); n++; end
      check_eq("rst_reach_wait", 512'(m_ce_at != old_ce && cyc == m_ce_at + 3), 512'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals();
      if_pend = 0; lsu_pend = 0; if_req_valid = 0; lsu_req_valid = 0; ddr_operation_done = 0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      lat_fix = -1;
      ifr0 = obs_if_rv; lsur0 = obs_lsu_rv;
      force_done = 1;
      tick();
      force_done = 0;
      repeat (10) tick();
      check_eq("rst_no_resp", 512'((obs_if_rv - ifr0) + (obs_lsu_rv - lsur0)), 512'(0));

      // More random traffic after reset.
      gen_en = 1;
      repeat (200) tick();
      gen_en = 0;
      run_until_idle(100);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ddr_req_arbiter.md
# ddr_req_arbiter

Initiator side of the simulated DDR interface: accepts cache-line requests from the instruction-fetch port and the load/store port, arbitrates between them, and drives one burst transaction at a time into `simddr`. It waits for `ddr_operation_done` and returns read data to the owning port with a one-cycle response pulse. A watchdog flags a DDR that never completes. It sits between the frontend/LSU and `simddr` in the sim top.

## Interface
- `TIMEOUT_CYCLES`, default 1024: WAIT cycles without `ddr_operation_done` before a timeout is declared.
- `clock` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `if_req_valid` in 1: fetch read request.
- `if_req_ready` out 1: fetch request accepted this cycle when high together with valid.
- `if_req_addr` in 64: fetch line address.
- `if_resp_valid` out 1: one-cycle fetch response pulse.
- `if_resp_data` out 512: fetch line data.
- `lsu_req_valid` in 1: LSU request.
- `lsu_req_ready` out 1: LSU request accepted this cycle when high together with valid.
- `lsu_req_addr` in 64: LSU line address.
- `lsu_req_wen` in 1: 1 = write, 0 = read.
- `lsu_req_wmask` in 512: write mask.
- `lsu_req_wdata` in 512: write data.
- `lsu_resp_valid` out 1: one-cycle LSU response pulse; also the write acknowledge.
- `lsu_resp_data` out 512: LSU read data.
- `ddr_chip_enable` out 1: one-cycle issue strobe.
- `ddr_index` out 64: address, passed through unmodified.
- `ddr_write_enable` out 1: write flag.
- `ddr_burst_mode` out 1: tied to 1 (512-bit only).
- `ddr_write_mask` out 512: write mask to DDR.
- `ddr_write_data` out 512: write data to DDR.
- `ddr_read_data` in 512: read data from DDR.
- `ddr_operation_done` in 1: completion pulse.
- `ddr_ready` in 1: DDR idle.
- `ddr_timeout` out 1: sticky watchdog error.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `x_req_ready` = (state==IDLE) & `ddr_ready` & grant_x. It is combinational and does not depend on `x_req_valid`.
  - On accept: latch addr, wen, wmask, wdata (fetch: wen=0, mask=0, data=0) and the owner ID, then go to ISSUE.
- **ISSUE**
  - `ddr_chip_enable`=1 for exactly one cycle.
  - `ddr_index`/`ddr_write_enable`/mask/data are driven from the latched registers. They stay stable from ISSUE until the next accept.
  - Go to WAIT.
- **WAIT**
  - Count cycles.
  - On `ddr_operation_done`: if read, capture `ddr_read_data` into the owner's resp_data register. Go to RESP.
  - If the count reaches `TIMEOUT_CYCLES` first: set `ddr_timeout` (sticky until reset), load the owner's resp_data with 0, and go to RESP.
- **RESP**
  - Owner's `resp_valid`=1 for one cycle, then go to IDLE.
  - Write completions pulse `lsu_resp_valid`; `lsu_resp_data` is unchanged.
- **Arbitration**: two-way round-robin with a last-grant register.
  - Single requester wins.
  - Both requesting: the port not granted last wins.
  - last-grant resets to LSU, so fetch wins the first tie.
  - last-grant updates only on accept.
- `ddr_operation_done` outside WAIT is ignored.
- Resp data registers hold their value between responses.
- The watchdog counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to WAIT.

## Timing
- Reset values:
  - state=IDLE.
  - all outputs 0, except `ddr_burst_mode`=1.
  - resp_data=0, `ddr_timeout`=0, last-grant=LSU.
- Accept at cycle T → `ddr_chip_enable` high in T+1 → WAIT from T+2.
- Done at cycle D → `resp_valid` high in D+1 → IDLE at D+2; next accept possible at D+2.
- One transaction in flight; no pipelining. Minimum 4 cycles between issues.
- `ddr_ready` low in IDLE blocks accept; both readies stay 0.
- Reset asserted mid-transaction: the transaction is dropped, `ddr_chip_enable` falls immediately, and no response is produced.

## Structure
- Package `ddr_if_pkg`: state enum, `DDR_LINE_W`=512, `DDR_ADDR_W`=64, owner ID enum (OWN_IF, OWN_LSU).
- Sub-module `rr_arb2`: 2-input round-robin arbiter holding the last-grant register, with a grant-update input driven by accept.

## Test plan
- Fetch read at 0x8000_0040 with DDR word memory preloaded: `ddr_chip_enable` pulses once with `ddr_index`=0x8000_0040, `ddr_write_enable`=0; `if_resp_valid` one cycle after done with the expected 512-bit line; `lsu_resp_valid` stays 0.
- LSU write to 0x8000_0100, data 0xA5 pattern: `ddr_write_enable`=1, data/mask match; `lsu_resp_valid` pulses; `lsu_resp_data` is unchanged.
- Both ports request in the same cycle, twice back-to-back: fetch is served first, LSU second; fetch re-requesting during the LSU transaction is held off (`if_req_ready`=0).
- `TIMEOUT_CYCLES`=16 and done forced low: `ddr_timeout` rises 16 WAIT cycles after ISSUE and stays high; the owner gets `resp_valid` with data 0.
- `ddr_ready` held low in IDLE with a request pending: no accept and no chip_enable. Raising `ddr_ready` gives accept that cycle.
- `reset_n` pulsed low during WAIT: all outputs go to reset values asynchronously; a later done pulse produces no response.
